// File: rtl/timer_counter.sv
// Memory-mapped countdown timer. Three word registers (CTRL, PRESET, COUNT)
// sit behind a 2-bit word select. COUNT loads from PRESET and counts down to
// zero, then raises irq_flag. Supports one-shot and auto-reload modes.
// Read data is combinational so the CPU can sample it in the same cycle.
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    state_e           state_q,  state_d;
    logic [3:0]       ctrl_q,   ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             flag_q,   flag_d;

    logic       ctrl_en;
    logic [1:0] ctrl_mode;
    logic       ctrl_im;
    logic       wr_ctrl;
    logic       wr_preset;

    assign ctrl_en   = ctrl_q[0];
    assign ctrl_mode = ctrl_q[2:1];
    assign ctrl_im   = ctrl_q[3];

    // COUNT and the reserved word are read-only, so only two write strobes exist.
    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_preset = we && (addr == ADDR_PRESET);

    assign irq = ctrl_im & flag_q;

    // State register: every register, including COUNT, clears on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Next-state logic: FSM effects first, then bus writes so a CPU write wins.
    always_comb begin
        // NOTE: hold-by-default on every output keeps this block latch-free.
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ctrl_en ? ST_CNT : ST_IDLE;
            end
            ST_CNT: begin
                if (!ctrl_en) begin
                    state_d = ST_IDLE;
                end else if (count_q > CNT_ONE) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    // A zero PRESET lands here too, so it expires like PRESET=1.
                    count_d = '0;
                    flag_d  = 1'b1;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_mode == MODE_RELOAD) begin
                    // Auto-reload: irq_flag is a single-cycle pulse.
                    flag_d = 1'b0;
                end else begin
                    // One-shot (and the unused 1x modes): stop, leave irq_flag level.
                    ctrl_d[0] = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_ctrl) begin
            ctrl_d = din[3:0];
            flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d = din[CNT_W-1:0];
            flag_d   = 1'b0;
        end
    end

    // Read mux: narrower registers zero-extend to the 32-bit bus.
    always_comb begin
        dout = '0;
        unique case (addr)
            ADDR_CTRL:   dout[3:0]       = ctrl_q;
            ADDR_PRESET: dout[CNT_W-1:0] = preset_q;
            ADDR_COUNT:  dout[CNT_W-1:0] = count_q;
            default:     dout            = '0;
        endcase
    end

endmodule
